dot_product_engine: RTL

Sequencer and multiply-accumulate stage that sits directly downstream of the on-chip single-port RAM holding the HPS-loaded 16-bit operand vectors. On `start` it walks two vectors (A and B) through the RAM's single read port, multiplies element pairs as signed 16-bit values, and accumulates the sum of products. It returns one scalar result with a one-cycle `done` pulse for the CPU-side control logic.

---
 rtl/dot_product_engine_if.sv | 38 +++
 rtl/dot_product_engine.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dot_product_engine_if.sv
// Bus bundle for dot_product_engine: CPU-side command/result signals and the
// single read port of the operand RAM.
//
// Command handshake: the requester raises `start` together with base_a,
// base_b and len; the engine accepts it only while idle (busy=0 and done=0),
// and a request outside that window is dropped rather than queued. Once
// accepted, `busy` stays high until the result is ready, then `done` pulses
// for exactly one cycle with `result`/`overflow` valid from that cycle on.
// `result` then holds until the next `done`.
interface dot_product_engine_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int ACC_WIDTH  = 40
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_a;
  logic [ADDR_WIDTH-1:0] base_b;
  logic [ADDR_WIDTH-1:0] len;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  busy;
  logic                  done;
  logic [ACC_WIDTH-1:0]  result;
  logic                  overflow;
  logic [2:0]            dbg_state;

  // CPU/RAM side: issues commands and returns RAM read data.
  modport master (
    output start, base_a, base_b, len, ram_q,
    input  ram_addr, busy, done, result, overflow, dbg_state
  );

  // Engine side.
  modport slave (
    input  start, base_a, base_b, len, ram_q,
    output ram_addr, busy, done, result, overflow, dbg_state
  );
endinterface

// File: rtl/dot_product_engine.sv
// Dot-product sequencer and MAC. Reads A[i] and B[i] alternately through the
// RAM's single read port, multiplies them as signed values and accumulates the
// sum of products, then reports the scalar result with a one-cycle done pulse.
// The multiply and accumulate stages trail the address sequencer by one and
// two cycles respectively, which is what the two drain states wait out.
module dot_product_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                 clk,
  input  logic                 reset_n,
  dot_product_engine_if.slave  bus
);

  localparam int PW = 2 * DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_A   = 3'd1,
    S_RD_B   = 3'd2,
    S_DRAIN1 = 3'd3,
    S_DRAIN2 = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                       state;
  logic [ADDR_WIDTH-1:0]        ram_addr_r;
  logic [ADDR_WIDTH-1:0]        base_a_r;
  logic [ADDR_WIDTH-1:0]        base_b_r;
  logic [ADDR_WIDTH-1:0]        len_r;
  logic [ADDR_WIDTH-1:0]        idx;
  logic signed [DATA_WIDTH-1:0] a_reg;
  logic signed [PW-1:0]         prod;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic                         mul_en;
  logic                         acc_en;
  logic [ACC_WIDTH-1:0]         result_r;
  logic                         done_r;
  logic                         busy_r;
  logic                         ovf_r;

  // Accumulator adder with signed-overflow detection on the wrapped sum.
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic                         acc_ovf;
  logic [ADDR_WIDTH-1:0]        idx_inc;
  logic                         last_pair;

  assign prod_ext  = ACC_WIDTH'(prod);
  assign acc_sum   = acc + prod_ext;
  assign acc_ovf   = (acc[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                     (acc_sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
  assign idx_inc   = idx + ADDR_WIDTH'(1);
  assign last_pair = (idx == (len_r - ADDR_WIDTH'(1)));

  // Sequencer FSM plus the multiply/accumulate pipeline, all registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      ram_addr_r <= '0;
      base_a_r   <= '0;
      base_b_r   <= '0;
      len_r      <= '0;
      idx        <= '0;
      a_reg      <= '0;
      prod       <= '0;
      acc        <= '0;
      mul_en     <= 1'b0;
      acc_en     <= 1'b0;
      result_r   <= '0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      // Multiply stage: the cycle after RD_B, ram_q carries B[i].
      mul_en <= (state == S_RD_B);
      if (mul_en) begin
        prod <= PW'(a_reg) * PW'($signed(bus.ram_q));
      end

      // Accumulate stage: one cycle after the product is formed.
      acc_en <= mul_en;
      if (acc_en) begin
        acc <= acc_sum;
        if (acc_ovf) begin
          ovf_r <= 1'b1;
        end
      end

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            ovf_r <= 1'b0;
            if (bus.len != '0) begin
              base_a_r   <= bus.base_a;
              base_b_r   <= bus.base_b;
              len_r      <= bus.len;
              idx        <= '0;
              acc        <= '0;
              ram_addr_r <= bus.base_a;
              busy_r     <= 1'b1;
              state      <= S_RD_A;
            end else begin
              // Empty vectors: report a zero result straight away.
              result_r <= '0;
              done_r   <= 1'b1;
              state    <= S_DONE;
            end
          end
        end

        S_RD_A: begin
          ram_addr_r <= base_b_r + idx;
          state      <= S_RD_B;
        end

        S_RD_B: begin
          a_reg <= $signed(bus.ram_q);
          if (!last_pair) begin
            idx        <= idx_inc;
            ram_addr_r <= base_a_r + idx_inc;
            state      <= S_RD_A;
          end else begin
            state <= S_DRAIN1;
          end
        end

        S_DRAIN1: begin
          state <= S_DRAIN2;
        end

        S_DRAIN2: begin
          // The final product is accumulated on this same edge, so the
          // result is taken from the adder rather than the stale acc.
          result_r <= acc_sum;
          done_r   <= 1'b1;
          busy_r   <= 1'b0;
          state    <= S_DONE;
        end

        S_DONE: begin
          done_r <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ram_addr  = ram_addr_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.result    = result_r;
  assign bus.overflow  = ovf_r;
  assign bus.dbg_state = state;

endmodule
